// File: rtl/multicycle_control.sv
// Multi-cycle RV32I-subset control FSM around a shared ALU.
// Moore outputs from state/instr; only FETCH and BRANCH strobes see inputs.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        EQ,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        AdrSrc,
  output logic        IRwrite,
  output logic        PCwrite,
  output logic        RegWrite,
  output logic [2:0]  ALUctrl,
  output logic [1:0]  ALUsrcA,
  output logic [1:0]  ALUsrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    LUI       = 4'd11,
    TRAP      = 4'd15
  } state_t;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SLT = 3'b101;
  localparam logic [2:0] SLL = 3'b110;
  localparam logic [2:0] SRL = 3'b111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t cur, nxt;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_lui;
  logic r_ok, i_ok, m_ok, b_ok;
  logic [2:0] alu_fn;
  logic unused_bits;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  assign is_r   = op == 7'b0110011;
  assign is_i   = op == 7'b0010011;
  assign is_ld  = op == 7'b0000011;
  assign is_st  = op == 7'b0100011;
  assign is_br  = op == 7'b1100011;
  assign is_jal = op == 7'b1101111;
  assign is_lui = op == 7'b0110111;

  // sltu/sltiu (011), sra/srai and stray funct7 bits all trap
  assign r_ok = (f7 == 7'h00 && f3 != 3'b011)
             || (f7 == 7'h20 && f3 == 3'b000);
  assign i_ok = f3 != 3'b011
             && (!(f3 == 3'b001 || f3 == 3'b101) || f7 == 7'h00);
  assign m_ok = f3 == 3'b010;
  assign b_ok = f3[2:1] == 2'b00;

  always_comb begin
    alu_fn = ADD;
    unique case (f3)
      3'b000:  alu_fn = (is_r && instr[30]) ? SUB : ADD;
      3'b001:  alu_fn = SLL;
      3'b010:  alu_fn = SLT;
      3'b100:  alu_fn = XOR;
      3'b101:  alu_fn = SRL;
      3'b110:  alu_fn = OR;
      3'b111:  alu_fn = AND;
      default: alu_fn = ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      FETCH:     if (mem_ready) nxt = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_r && r_ok:                    nxt = EXEC_R;
          is_i && i_ok:                    nxt = EXEC_I;
          (is_ld || is_st) && m_ok:        nxt = MEM_ADDR;
          is_br && b_ok:                   nxt = BRANCH;
          is_jal:                          nxt = JAL;
          is_lui:                          nxt = LUI;
          default:                         nxt = TRAP;
        endcase
      end
      MEM_ADDR:  nxt = is_st ? MEM_WRITE : MEM_READ;
      MEM_READ:  if (mem_ready) nxt = MEM_WB;
      MEM_WRITE: if (mem_ready) nxt = FETCH;
      MEM_WB:    nxt = FETCH;
      EXEC_R:    nxt = ALU_WB;
      EXEC_I:    nxt = ALU_WB;
      JAL:       nxt = ALU_WB;
      LUI:       nxt = ALU_WB;
      ALU_WB:    nxt = FETCH;
      BRANCH:    nxt = FETCH;
      TRAP:      nxt = TRAP;
      default:   nxt = TRAP;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    AdrSrc    = 1'b0;
    IRwrite   = 1'b0;
    PCwrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = ADD;
    ALUsrcA   = 2'b00;
    ALUsrcB   = 2'b00;
    ResultSrc = 2'b00;
    ImmSrc    = IMM_I;
    if (!rst) begin
      unique case (cur)
        FETCH: begin
          mem_req   = 1'b1;
          ALUsrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRwrite   = mem_ready;
          PCwrite   = mem_ready;
        end
        DECODE: begin
          ALUsrcA = 2'b01;
          ALUsrcB = 2'b01;
          ImmSrc  = is_br ? IMM_B : IMM_J;
        end
        MEM_ADDR: begin
          ALUsrcA = 2'b10;
          ALUsrcB = 2'b01;
          ImmSrc  = is_st ? IMM_S : IMM_I;
        end
        MEM_READ: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEM_WB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          AdrSrc  = 1'b1;
        end
        EXEC_R: begin
          ALUsrcA = 2'b10;
          ALUctrl = alu_fn;
        end
        EXEC_I: begin
          ALUsrcA = 2'b10;
          ALUsrcB = 2'b01;
          ALUctrl = alu_fn;
        end
        ALU_WB:  RegWrite = 1'b1;
        BRANCH: begin
          ALUsrcA = 2'b10;
          ALUctrl = SUB;
          PCwrite = f3[0] ? ~EQ : EQ;
        end
        JAL: begin
          PCwrite = 1'b1;
          ALUsrcA = 2'b01;
          ALUsrcB = 2'b10;
        end
        LUI: begin
          ALUsrcA = 2'b11;
          ALUsrcB = 2'b01;
          ImmSrc  = IMM_U;
        end
        default: ;
      endcase
    end
  end

  assign illegal = cur == TRAP;
  assign state   = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle scripts
// expand into expected output records compared every cycle.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        EQ = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, AdrSrc, IRwrite, PCwrite, RegWrite;
  logic [2:0]  ALUctrl, ImmSrc;
  logic [1:0]  ALUsrcA, ALUsrcB, ResultSrc;
  logic        illegal;
  logic [3:0]  state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .EQ(EQ),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .AdrSrc(AdrSrc), .IRwrite(IRwrite), .PCwrite(PCwrite),
    .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic req, we, adr, irw, pcw, rw;
    logic [2:0] alu;
    logic [1:0] sa, sb, rs;
    logic [2:0] imm;
    logic ill;
  } exp_t;

  typedef struct {
    logic rst, rdy, eq, chk;
    logic [31:0] ins;
    exp_t e;
  } cyc_t;

  cyc_t sched[$];
  cyc_t cur;
  logic act = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t got;

  assign got = {state, mem_req, mem_we, AdrSrc, IRwrite, PCwrite,
                RegWrite, ALUctrl, ALUsrcA, ALUsrcB, ResultSrc,
                ImmSrc, illegal};

  function automatic exp_t z(input int st);
    exp_t e;
    e = '0;
    e.st = st[3:0];
    return e;
  endfunction

  // funct3 -> ALU op, indexed by funct3 value
  function automatic logic [2:0] alu_of(input logic [31:0] i);
    logic [2:0] tab [8];
    logic [2:0] r;
    tab = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
    r = tab[i[14:12]];
    if (i[6:0] == 7'h33 && i[30]) r = 3'd1;
    return r;
  endfunction

  function automatic bit legal(input logic [31:0] i);
    int f3, f7;
    f3 = int'(i[14:12]);
    f7 = int'(i[31:25]);
    case (i[6:0])
      7'h33: return (f7 == 0 && f3 != 3) || (f7 == 32 && f3 == 0);
      7'h13: return f3 != 3 && ((f3 != 1 && f3 != 5) || f7 == 0);
      7'h03, 7'h23: return f3 == 2;
      7'h63: return f3 < 2;
      7'h6F, 7'h37: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic push(input logic r, input logic rdy, input logic eq,
                      input logic [31:0] ins, input exp_t e);
    cyc_t c;
    c.rst = r; c.rdy = rdy; c.eq = eq; c.chk = 1'b1;
    c.ins = ins; c.e = e;
    sched.push_back(c);
  endtask

  task automatic do_instr(input logic [31:0] ins, input int fw,
                          input int mw, input logic eq,
                          input bit abort, input int ntrap);
    exp_t e;
    logic [6:0] op;
    op = ins[6:0];
    e = z(0); e.req = 1; e.sb = 2; e.rs = 2;
    repeat (fw) push(0, 0, eq, ins, e);
    e.irw = 1; e.pcw = 1;
    push(0, 1, eq, ins, e);
    e = z(1); e.sa = 1; e.sb = 1; e.imm = (op == 7'h63) ? 3'd2 : 3'd3;
    push(0, 1, eq, ins, e);
    if (!legal(ins)) begin
      e = z(15); e.ill = 1;
      repeat (ntrap) push(0, 1, eq, ins, e);
      push(1, 1, eq, ins, e);
      return;
    end
    case (op)
      7'h33: begin
        e = z(6); e.sa = 2; e.alu = alu_of(ins);
        push(0, 1, eq, ins, e);
      end
      7'h13: begin
        e = z(7); e.sa = 2; e.sb = 1; e.alu = alu_of(ins);
        push(0, 1, eq, ins, e);
      end
      7'h03, 7'h23: begin
        e = z(2); e.sa = 2; e.sb = 1; e.imm = {2'b00, op[5]};
        push(0, 1, eq, ins, e);
        e = z(op[5] ? 5 : 3); e.req = 1; e.adr = 1; e.we = op[5];
        repeat (mw) push(0, 0, eq, ins, e);
        if (abort) begin
          push(1, 0, eq, ins, z(op[5] ? 5 : 3));
          return;
        end
        push(0, 1, eq, ins, e);
        if (!op[5]) begin
          e = z(4); e.rs = 1; e.rw = 1;
          push(0, 1, eq, ins, e);
        end
        return;
      end
      7'h63: begin
        e = z(9); e.sa = 2; e.alu = 1;
        e.pcw = ins[12] ? ~eq : eq;
        push(0, 1, eq, ins, e);
        return;
      end
      7'h6F: begin
        e = z(10); e.pcw = 1; e.sa = 1; e.sb = 2;
        push(0, 1, eq, ins, e);
      end
      default: begin
        e = z(11); e.sa = 3; e.sb = 1; e.imm = 4;
        push(0, 1, eq, ins, e);
      end
    endcase
    e = z(8); e.rw = 1;
    push(0, 1, eq, ins, e);
  endtask

  task automatic pin(input string nm, input int g, input int w);
    tests++;
    if (g != w) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, g, w);
    end
  endtask

  task automatic timed(input string nm, input logic [31:0] ins,
                       input int fw, input int mw, input logic eq,
                       input int want);
    int n;
    n = sched.size();
    do_instr(ins, fw, mw, eq, 0, 0);
    pin(nm, sched.size() - n, want);
  endtask

  always @(negedge clk) begin
    if (act && cur.chk) begin
      tests++;
      if (got !== cur.e) begin
        fails++;
        $display("FAIL cycle st=%0d ins=%h: got %h want %h",
                 cur.e.st, cur.ins, got, cur.e);
      end
    end
  end

  initial begin
    push(1, 0, 0, 32'h0, z(0));
    pin("sra legal", int'(legal(32'h4020D133)), 0);
    pin("sub alu", int'(alu_of(32'h40208133)), 1);
    pin("srli alu", int'(alu_of(32'h0050D093)), 7);
    timed("sub len",  32'h40208133, 0, 0, 0, 4);
    timed("lw len",   32'h0040A183, 0, 2, 0, 7);
    timed("beq1 len", 32'h00208463, 0, 0, 1, 3);
    timed("beq0 len", 32'h00208463, 0, 0, 0, 3);
    timed("bne1 len", 32'h00209463, 0, 0, 1, 3);
    timed("bne0 len", 32'h00209463, 0, 0, 0, 3);
    timed("jal len",  32'h008000EF, 0, 0, 0, 4);
    timed("addi len", 32'h00508093, 1, 0, 0, 5);
    timed("slti len", 32'h0050A093, 0, 0, 0, 4);
    timed("srli len", 32'h0050D093, 0, 0, 0, 4);
    timed("and len",  32'h0020F1B3, 0, 0, 0, 4);
    timed("lui len",  32'h123450B7, 0, 0, 0, 4);
    timed("sw len",   32'h0020A223, 0, 0, 0, 4);
    timed("lw0 len",  32'h0040A183, 2, 0, 0, 7);
    do_instr(32'h0020A223, 0, 1, 0, 1, 0);
    do_instr(32'h4020D133, 0, 0, 1, 0, 20);
    do_instr(32'h00000000, 0, 0, 0, 0, 3);
    do_instr(32'h0010B093, 0, 0, 0, 0, 2);
    do_instr(32'h002081B3, 0, 0, 0, 0, 0);

    foreach (sched[k]) begin
      @(posedge clk);
      #1;
      rst       = sched[k].rst;
      mem_ready = sched[k].rdy;
      EQ        = sched[k].eq;
      instr     = sched[k].ins;
      cur       = sched[k];
      act       = 1'b1;
    end
    @(posedge clk);
    #1 act = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle RV32I-subset control unit that sequences the datapath around the shared ALU. Decodes the registered instruction, drives `ALUctrl` and operand selects each cycle, and walks a Moore FSM through fetch, decode, execute, memory and writeback. Uses the ALU `EQ` flag to resolve branches, and talks to a unified instruction/data memory through a req/ready handshake. Datapath registers (PC, oldPC, IR, A, B, ALUOut, MDR) live outside this block; it only drives their enables and muxes.

## Interface
- no parameters; instruction width fixed at 32

- `clk  in  1`  system clock
- `rst  in  1`  synchronous, active-high reset
- `instr  in  32`  instruction register contents, valid from DECODE onward
- `EQ  in  1`  ALU equality flag (ALUop1 == ALUop2)
- `mem_ready  in  1`  memory completes the current request this cycle
- `mem_req  out  1`  memory request, held until `mem_ready`
- `mem_we  out  1`  request is a store
- `AdrSrc  out  1`  memory address: 0 = PC, 1 = ALUOut
- `IRwrite  out  1`  load IR and oldPC
- `PCwrite  out  1`  load PC from result bus
- `RegWrite  out  1`  write rd from result bus
- `ALUctrl  out  3`  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- `ALUsrcA  out  2`  00 PC, 01 oldPC, 10 A (rs1), 11 zero
- `ALUsrcB  out  2`  00 B (rs2), 01 immediate, 10 constant 4
- `ResultSrc  out  2`  00 ALUOut register, 01 MDR, 10 live ALU output
- `ImmSrc  out  3`  000 I, 001 S, 010 B, 011 J, 100 U
- `illegal  out  1`  sticky: undecodable instruction seen
- `state  out  4`  current state encoding, for debug

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, JAL = 10, LUI = 11, TRAP = 15
- FETCH
  - Outputs: `mem_req`=1, `AdrSrc`=0, ALU = PC + 4 (A = 00, B = 10, add), `ResultSrc`=10.
  - Stays in FETCH while `mem_ready`=0.
  - When `mem_ready`=1: `IRwrite`=1 and `PCwrite`=1 in that same cycle, then go to DECODE.
- DECODE
  - ALU = oldPC + imm (A = 01, B = 01, add), with `ImmSrc` = B for branches and J otherwise. The result is latched into ALUOut as the branch/jump target.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - anything else → TRAP
- Legal instruction encodings:
  - R-type: funct3/funct7 of 000/0000000 add, 000/0100000 sub, 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101/0000000 srl.
  - I-type ALU: same funct3 set, no sub. slli/srli require funct7 = 0.
  - lw/sw require funct3 = 010.
  - Branches: funct3 000 beq, 001 bne.
  - Every other combination (including sra/srai) → TRAP.
- EXEC_R: A = 10, B = 00, `ALUctrl` from funct3/funct7 → ALU_WB.
- EXEC_I: A = 10, B = 01, `ImmSrc` = I, `ALUctrl` from funct3 → ALU_WB.
- ALU_WB: `ResultSrc`=00, `RegWrite`=1 → FETCH.
- MEM_ADDR: A = 10, B = 01, add; `ImmSrc` = I for lw, S for sw. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: `mem_req`=1, `AdrSrc`=1. Waits for `mem_ready`, then → MEM_WB.
- MEM_WB: `ResultSrc`=01, `RegWrite`=1 → FETCH.
- MEM_WRITE: `mem_req`=1, `mem_we`=1, `AdrSrc`=1. Waits for `mem_ready`, then → FETCH.
- BRANCH
  - A = 10, B = 00, sub, `ResultSrc`=00.
  - `PCwrite` = `EQ` for beq and `~EQ` for bne → FETCH.
- JAL
  - Drives PC := ALUOut (`ResultSrc`=00, `PCwrite`=1).
  - Computes oldPC + 4 (A = 01, B = 10) → ALU_WB.
- LUI: A = 11, B = 01, `ImmSrc` = U, add → ALU_WB.
- TRAP
  - `illegal`=1, all strobes 0.
  - Terminal until `rst`.
- Any output not listed for a state is 0.

## Timing
- Reset
  - `rst` sampled high → state = FETCH and `illegal` = 0 on that edge.
  - While `rst`=1, all strobes (`mem_req`, `mem_we`, `IRwrite`, `PCwrite`, `RegWrite`) are forced to 0 and all selects read 0.
  - Reset takes effect from any state, including mid-wait in FETCH, MEM_READ or MEM_WRITE; the pending request is dropped.
- Output timing
  - Outputs are combinational from the registered state and `instr`.
  - The only input-gated outputs are `IRwrite`/`PCwrite` in FETCH (gated by `mem_ready`) and `PCwrite` in BRANCH (gated by `EQ`).
- Memory handshake
  - `mem_req` asserts in the first cycle of a memory state.
  - `mem_req`, `mem_we` and `AdrSrc` stay stable until the cycle in which `mem_ready`=1.
  - `mem_ready` outside a memory state is ignored.
- Latency with zero-wait memory (`mem_ready` always 1):
  - R/I-type and lui: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - jal: 4 cycles
- Each memory wait cycle adds exactly 1 cycle.

## Test plan
- R-type: after reset, `instr`=0x40208133 (sub x2,x1,x2), `mem_ready`=1 → states 0,1,6,8,0. `ALUctrl`=001 in EXEC_R; `RegWrite`=1 only in state 8.
- lw with wait: `instr`=0x0040A183 (lw x3,4(x1)), `mem_ready` low for 2 cycles in MEM_READ → `mem_req`/`AdrSrc` held for 3 cycles. MEM_WB follows with `ResultSrc`=01 and `RegWrite`=1.
- Branch resolution: beq 0x00208463.
  - `EQ`=1 in BRANCH → `PCwrite`=1.
  - `EQ`=0 → `PCwrite`=0.
  - bne (funct3 001) gives the inverse result in each case.
  - Both cases return to FETCH after 3 cycles.
- jal 0x008000EF → states 0,1,10,8. `PCwrite`=1 in JAL; A = 01, B = 10 in JAL; `RegWrite`=1 in ALU_WB.
- Illegal: `instr`=0x4020D133 (sra) → TRAP (`state`=15) after DECODE. `illegal` stays 1 and strobes stay 0 for 20 cycles; `rst` pulse → FETCH, `illegal`=0.
- Reset mid-wait: assert `rst` in MEM_WRITE while `mem_ready`=0 → `mem_req`/`mem_we` drop to 0 in the reset cycle, and `state`=0 on the next edge.
